// File: rtl/priv_1_11_redirect_ctrl.sv
// Trap/MRET redirect controller: captures the machine-mode target, waits for the
// pipeline to drain, then presents the redirect to fetch until it is accepted.
module priv_1_11_redirect_ctrl #(
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned CAUSE_W     = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    intr,
  input  logic                    ret,
  input  logic                    pipe_clear,
  input  logic [3:0][31:0]        xtvec,
  input  logic [3:0][31:0]        xepc_r,
  input  logic                    cause_int,
  input  logic [CAUSE_W-1:0]      cause_code,
  input  logic                    fetch_ready,
  output logic                    insert_pc,
  output logic [31:0]             priv_pc,
  output logic                    redirect_busy,
  output logic [15:0]             redirect_count
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE} state_t;

  state_t          state;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] base_c;
  logic [PC_W-1:0] trap_target_c;
  logic            vectored_c;
  logic            unused_inputs;

  // Only the machine-level vector and EPC are consumed.
  assign unused_inputs = ^{xtvec[2:0], xepc_r[2:0]};

  // Vectoring applies to interrupts in mode 1 only; modes 0, 2, 3 are direct.
  assign base_c        = {xtvec[3][31:2], 2'b00};
  assign vectored_c    = VECTORED_EN && cause_int && (xtvec[3][1:0] == 2'b01);
  assign trap_target_c = vectored_c ? base_c + (PC_W'(cause_code) << 2) : base_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      target         <= '0;
      insert_pc      <= 1'b0;
      priv_pc        <= '0;
      redirect_busy  <= 1'b0;
      redirect_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // intr wins over a simultaneous ret
          if (intr || ret) begin
            target        <= intr ? trap_target_c : xepc_r[3];
            state         <= DRAIN;
            redirect_busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (pipe_clear) begin
            state     <= ISSUE;
            insert_pc <= 1'b1;
            priv_pc   <= target;
          end
        end
        ISSUE: begin
          if (fetch_ready) begin
            state          <= IDLE;
            insert_pc      <= 1'b0;
            priv_pc        <= '0;
            redirect_busy  <= 1'b0;
            redirect_count <= redirect_count + CNT_W'(1);
          end
        end
        default: begin
          state         <= IDLE;
          insert_pc     <= 1'b0;
          priv_pc       <= '0;
          redirect_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priv_1_11_redirect_ctrl.sv
// Directed bench for priv_1_11_redirect_ctrl; a second instance with vectoring
// disabled shares the stimulus so direct-only targets can be compared side by side.
module tb_priv_1_11_redirect_ctrl;

  logic             CLK = 1'b0;
  logic             RST;
  logic             intr, ret, pipe_clear, cause_int, fetch_ready;
  logic [3:0][31:0] xtvec, xepc_r;
  logic [4:0]       cause_code;

  logic        insert1, busy1, insert0, busy0;
  logic [31:0] priv1, priv0;
  logic [15:0] count1, count0;

  int checks   = 0;
  int failures = 0;
  logic [15:0] cnt_exp = 16'd0;

  priv_1_11_redirect_ctrl #(.VECTORED_EN(1'b1), .CAUSE_W(5)) dut (
    .CLK(CLK), .RST(RST), .intr(intr), .ret(ret), .pipe_clear(pipe_clear),
    .xtvec(xtvec), .xepc_r(xepc_r), .cause_int(cause_int), .cause_code(cause_code),
    .fetch_ready(fetch_ready), .insert_pc(insert1), .priv_pc(priv1),
    .redirect_busy(busy1), .redirect_count(count1)
  );

  priv_1_11_redirect_ctrl #(.VECTORED_EN(1'b0), .CAUSE_W(5)) dut_direct (
    .CLK(CLK), .RST(RST), .intr(intr), .ret(ret), .pipe_clear(pipe_clear),
    .xtvec(xtvec), .xepc_r(xepc_r), .cause_int(cause_int), .cause_code(cause_code),
    .fetch_ready(fetch_ready), .insert_pc(insert0), .priv_pc(priv0),
    .redirect_busy(busy0), .redirect_count(count0)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Minimum-latency redirect: request, one DRAIN cycle, ISSUE accepted at once.
  task automatic run_min(input logic i, input logic r, input logic [31:0] exp1,
                         input logic [31:0] exp0, input string tag);
    intr = i; ret = r; pipe_clear = 1'b1; fetch_ready = 1'b1;
    tick();
    intr = 1'b0; ret = 1'b0;
    chk({tag, "_n1_busy"}, 32'(busy1), 32'd1);
    chk({tag, "_n1_insert"}, 32'(insert1), 32'd0);
    tick();
    chk({tag, "_n2_insert"}, 32'(insert1), 32'd1);
    chk({tag, "_n2_pc"}, priv1, exp1);
    chk({tag, "_n2_pc_direct"}, priv0, exp0);
    tick();
    cnt_exp = cnt_exp + 16'd1;
    chk({tag, "_n3_insert"}, 32'(insert1), 32'd0);
    chk({tag, "_n3_busy"}, 32'(busy1), 32'd0);
    chk({tag, "_n3_pc"}, priv1, 32'd0);
    chk({tag, "_count"}, 32'(count1), 32'(cnt_exp));
  endtask

  initial begin
    RST = 1'b1; intr = 1'b1; ret = 1'b1; pipe_clear = 1'b1; fetch_ready = 1'b1;
    cause_int = 1'b0; cause_code = 5'd0; xtvec = '0; xepc_r = '0;
    // Requests held during reset are discarded
    tick(); tick();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_insert", 32'(insert1), 32'd0);
    chk("rst_pc", priv1, 32'd0);
    chk("rst_count", 32'(count1), 32'd0);
    RST = 1'b0; intr = 1'b0; ret = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy1), 32'd0);

    // Direct exception
    xtvec[3] = 32'h8000_0100; cause_int = 1'b0; cause_code = 5'd3;
    run_min(1'b1, 1'b0, 32'h8000_0100, 32'h8000_0100, "direct_exc");

    // Vectored interrupt; inputs changed after capture must not matter
    xtvec[3] = 32'h8000_0101; cause_int = 1'b1; cause_code = 5'd7;
    intr = 1'b1; pipe_clear = 1'b1; fetch_ready = 1'b1;
    tick();
    intr = 1'b0; xtvec[3] = 32'h0; cause_code = 5'd0; cause_int = 1'b0;
    tick();
    chk("vec_pc", priv1, 32'h8000_011C);
    chk("vec_pc_direct", priv0, 32'h8000_0100);
    tick();
    cnt_exp = cnt_exp + 16'd1;
    chk("vec_count", 32'(count1), 32'(cnt_exp));

    // Mode 3 and exceptions in mode 1 are direct
    xtvec[3] = 32'h8000_0103; cause_int = 1'b1; cause_code = 5'd7;
    run_min(1'b1, 1'b0, 32'h8000_0100, 32'h8000_0100, "mode3");
    xtvec[3] = 32'h8000_0101; cause_int = 1'b0;
    run_min(1'b1, 1'b0, 32'h8000_0100, 32'h8000_0100, "vec_exc");

    // MRET with 5 extra drain cycles; intr during DRAIN is ignored
    xepc_r[3] = 32'h0000_2004; xtvec[3] = 32'h8000_0100;
    ret = 1'b1; pipe_clear = 1'b0; fetch_ready = 1'b0;
    tick();
    ret = 1'b0; intr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mret_drain%0d_busy", k), 32'(busy1), 32'd1);
      chk($sformatf("mret_drain%0d_insert", k), 32'(insert1), 32'd0);
      tick();
    end
    pipe_clear = 1'b1;
    chk("mret_pre_issue_insert", 32'(insert1), 32'd0);
    tick();
    chk("mret_issue_insert", 32'(insert1), 32'd1);
    chk("mret_issue_pc", priv1, 32'h0000_2004);
    intr = 1'b0; fetch_ready = 1'b1;
    tick();
    cnt_exp = cnt_exp + 16'd1;
    chk("mret_done_busy", 32'(busy1), 32'd0);
    chk("mret_count", 32'(count1), 32'(cnt_exp));

    // Simultaneous intr+ret with fetch back-pressure
    xtvec[3] = 32'h8000_0200; cause_int = 1'b0; xepc_r[3] = 32'h0000_3000;
    intr = 1'b1; ret = 1'b1; pipe_clear = 1'b1; fetch_ready = 1'b0;
    tick();
    intr = 1'b0; ret = 1'b0;
    tick();
    xtvec[3] = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("both_stall%0d_insert", k), 32'(insert1), 32'd1);
      chk($sformatf("both_stall%0d_pc", k), priv1, 32'h8000_0200);
      tick();
    end
    chk("both_stall_count", 32'(count1), 32'(cnt_exp));
    fetch_ready = 1'b1;
    tick();
    cnt_exp = cnt_exp + 16'd1;
    chk("both_count", 32'(count1), 32'(cnt_exp));
    tick();
    chk("both_single", 32'(count1), 32'(cnt_exp));

    // Target wrap-around
    xtvec[3] = 32'hFFFF_FFF1; cause_int = 1'b1; cause_code = 5'd31;
    run_min(1'b1, 1'b0, 32'h0000_006C, 32'hFFFF_FFF0, "wrap_pc");

    // Back-to-back: held intr recaptured in the IDLE cycle after completion
    xtvec[3] = 32'h8000_0100; cause_int = 1'b0;
    intr = 1'b1; pipe_clear = 1'b1; fetch_ready = 1'b1;
    tick(); chk("b2b_e1_busy", 32'(busy1), 32'd1);
    tick(); chk("b2b_e2_insert", 32'(insert1), 32'd1);
    tick(); chk("b2b_e3_busy", 32'(busy1), 32'd0);
    tick(); chk("b2b_e4_busy", 32'(busy1), 32'd1);
    intr = 1'b0;
    tick(); chk("b2b_e5_insert", 32'(insert1), 32'd1);
    tick(); chk("b2b_e6_busy", 32'(busy1), 32'd0);
    cnt_exp = cnt_exp + 16'd2;
    chk("b2b_count", 32'(count1), 32'(cnt_exp));

    // Counter wrap from 0xFFFF
    @(negedge CLK);
    force dut.redirect_count = 16'hFFFF;
    #1 release dut.redirect_count;
    tick();
    cnt_exp = 16'hFFFF;
    run_min(1'b1, 1'b0, 32'h8000_0100, 32'h8000_0100, "cnt_wrap");

    // Reset during ISSUE aborts without counting
    intr = 1'b1; fetch_ready = 1'b0;
    tick(); intr = 1'b0;
    tick();
    chk("abort_issue_insert", 32'(insert1), 32'd1);
    RST = 1'b1; fetch_ready = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_insert", 32'(insert1), 32'd0);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_pc", priv1, 32'd0);
    chk("abort_count", 32'(count1), 32'd0);
    cnt_exp = 16'd0;
    xtvec[3] = 32'h8000_0400;
    run_min(1'b1, 1'b0, 32'h8000_0400, 32'h8000_0400, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priv_1_11_redirect_ctrl.md
PRIV_1_11_REDIRECT_CTRL -- requirements
Module: priv_1_11_redirect_ctrl

Interface
REQ-001 Parameter VECTORED_EN, default 1; 1 enables mtvec vectored-mode target computation for interrupts, 0 forces direct mode.
REQ-002 Parameter CAUSE_W, default 5; width of the interrupt cause code used for vectoring.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 intr  input  1  trap request (exception or interrupt) from privilege control.
REQ-006 ret  input  1  MRET request.
REQ-007 pipe_clear  input  1  pipeline drained, no older instruction in flight.
REQ-008 xtvec  input  4x32  per-privilege trap vector; index 3 (machine) used; bits[1:0] = mode (0 direct, 1 vectored).
REQ-009 xepc_r  input  4x32  per-privilege exception PC; index 3 used.
REQ-010 cause_int  input  1  current mcause interrupt bit.
REQ-011 cause_code  input  CAUSE_W  current mcause exception code.
REQ-012 fetch_ready  input  1  fetch stage accepts the redirect this cycle.
REQ-013 insert_pc  output  1  redirect valid to fetch.
REQ-014 priv_pc  output  32  redirect target PC.
REQ-015 redirect_busy  output  1  high in any state other than IDLE; stalls issue upstream.
REQ-016 redirect_count  output  16  count of completed redirects.

Function
REQ-017 FSM states SHALL be IDLE, DRAIN, ISSUE.
REQ-018 In IDLE, intr or ret high SHALL capture target into an internal register and transition to DRAIN on the next edge.
REQ-019 Simultaneous intr and ret in IDLE SHALL service intr only; ret is dropped.
REQ-020 intr target SHALL be {xtvec[3][31:2],2'b00} in direct mode, exceptions, or VECTORED_EN=0.
REQ-021 intr target with mode=1, cause_int=1 and VECTORED_EN=1 SHALL be {xtvec[3][31:2],2'b00} + (cause_code zero-extended << 2), 32-bit wrap-around, carry discarded.
REQ-022 Mode values 2 and 3 SHALL be treated as direct.
REQ-023 ret target SHALL be xepc_r[3] unmodified.
REQ-024 Target, cause and mode SHALL be sampled only in the IDLE capture cycle; later input changes do not affect the captured target.
REQ-025 DRAIN SHALL remain until pipe_clear=1, then go to ISSUE on that edge; pipe_clear already high at capture still costs one DRAIN cycle.
REQ-026 ISSUE SHALL drive insert_pc=1 and priv_pc=captured target; hold both stable until fetch_ready=1.
REQ-027 ISSUE with fetch_ready=1 SHALL return to IDLE next edge and increment redirect_count by 1, wrapping 0xFFFF->0x0000.
REQ-028 Minimum latency SHALL be: request at cycle N, insert_pc high at N+2, earliest accept at N+2, IDLE at N+3.
REQ-029 intr/ret asserted in DRAIN or ISSUE SHALL be ignored; upstream holds level requests until serviced.
REQ-030 A new request in the IDLE cycle immediately after completion SHALL be captured normally (back-to-back).
REQ-031 insert_pc SHALL be 0 and priv_pc SHALL be 0 outside ISSUE.
REQ-032 redirect_busy SHALL equal (state != IDLE), registered-state derived, no combinational path from intr/ret.

Reset
REQ-033 RST=1 at a rising edge SHALL force IDLE, captured target=0, redirect_count=0, insert_pc=0, priv_pc=0, redirect_busy=0.
REQ-034 RST in DRAIN or ISSUE SHALL abort the redirect with no count increment; RST overrides all other inputs in that cycle.
REQ-035 Requests coincident with RST SHALL be discarded; capture allowed from first cycle after RST deasserts.

Verification
REQ-036 Direct exception: xtvec[3]=0x8000_0100, cause_int=0, intr pulse, pipe_clear=1, fetch_ready=1 -> insert_pc at N+2, priv_pc=0x8000_0100, count=1.
REQ-037 Vectored interrupt: xtvec[3]=0x8000_0101, cause_int=1, cause_code=7 -> priv_pc=0x8000_011C; same with VECTORED_EN=0 -> 0x8000_0100.
REQ-038 MRET with drain stall: xepc_r[3]=0x0000_2004, ret pulse, pipe_clear low 5 cycles -> busy 7+ cycles, insert_pc only after pipe_clear, priv_pc=0x0000_2004.
REQ-039 Simultaneous intr+ret, fetch_ready low 3 ISSUE cycles -> trap target issued, priv_pc stable all 3 cycles, single count increment.
REQ-040 Wrap: xtvec[3]=0xFFFF_FFF1, cause_code=31 -> priv_pc=0x0000_006C; count preloaded via 65535 redirects -> next completion yields 0x0000.
REQ-041 RST asserted in ISSUE -> next cycle insert_pc=0, busy=0, count unchanged to 0; following intr serviced normally.
